// File: rtl/data_mem_bridge.sv
// data_mem_bridge: connects the CPU data port to a req/ack word RAM, posting stores into a FIFO.
// Define DMB_FORWARD_EN to enable store-to-load forwarding from the write buffer.
module data_mem_bridge #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic          cpu_read,
  input  logic          cpu_write,
  output logic [31:0]   cpu_rdata,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [29:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic [CW-1:0] wb_count
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, READ, DONE} state_t;

  state_t         state, state_next;
  logic [29:0]    wb_addr [DEPTH];
  logic [31:0]    wb_data [DEPTH];
  logic [PW-1:0]  head, tail, head_next;
  logic [CW-1:0]  count, count_next;
  logic [29:0]    word_addr;
  logic           addr_lsb_unused;
  logic           full, push, pop, rd_ack;
  logic           req_next, we_next;
  logic [29:0]    addr_next;
  logic [31:0]    wdata_next;

  assign word_addr       = cpu_addr[31:2];
  assign addr_lsb_unused = ^cpu_addr[1:0];
  assign full            = (count == CW'(DEPTH));
  assign push            = cpu_write && !cpu_read && !full;
  assign pop             = (state == DRAIN) && mem_req && mem_ack;
  assign rd_ack          = (state == READ) && mem_req && mem_ack;
  assign head_next       = pop ? head + PW'(1) : head;
  assign wb_count        = count;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

`ifdef DMB_FORWARD_EN
  // Newest matching entry wins; the head is excluded on the edge it is being popped.
  logic        fwd_hit;
  logic [31:0] fwd_data;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && !(pop && (k == 0)) &&
          (wb_addr[head + PW'(k)] == word_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[head + PW'(k)];
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
`ifdef DMB_FORWARD_EN
        if (cpu_read && fwd_hit)
          state_next = DONE;
        else if (cpu_read)
          state_next = READ;
        else if (count != '0)
          state_next = DRAIN;
`else
        if (cpu_read && (count == '0))
          state_next = READ;
        else if (count != '0)
          state_next = DRAIN;
`endif
      end
      DRAIN: begin
        if (pop) begin
`ifdef DMB_FORWARD_EN
          if (cpu_read && fwd_hit)
            state_next = DONE;
          else if (cpu_read)
            state_next = READ;
          else if (count_next != '0)
            state_next = DRAIN;
          else
            state_next = IDLE;
`else
          if (cpu_read && (count_next == '0))
            state_next = READ;
          else if (count_next != '0)
            state_next = DRAIN;
          else
            state_next = IDLE;
`endif
        end
      end
      READ: begin
        if (rd_ack)
          state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory-side values are computed from the next state so they are registered on entry.
  always_comb begin
    stall      = reset && ((cpu_read && (state != DONE)) ||
                           (cpu_write && !cpu_read && full));
    req_next   = (state_next == DRAIN) || (state_next == READ);
    we_next    = (state_next == DRAIN);
    addr_next  = mem_addr;
    wdata_next = mem_wdata;
    if (state_next == DRAIN) begin
      if (pop && (count == CW'(1))) begin
        addr_next  = word_addr;
        wdata_next = cpu_wdata;
      end else begin
        addr_next  = wb_addr[head_next];
        wdata_next = wb_data[head_next];
      end
    end else if (state_next == READ) begin
      addr_next  = word_addr;
      wdata_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_req   <= req_next;
      mem_we    <= we_next;
      mem_addr  <= addr_next;
      mem_wdata <= wdata_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      count <= count_next;
      if (push)
        tail <= tail + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[tail] <= word_addr;
      wb_data[tail] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cpu_rdata <= '0;
    else if (rd_ack)
      cpu_rdata <= mem_rdata;
`ifdef DMB_FORWARD_EN
    else if (state_next == DONE)
      cpu_rdata <= fwd_data;
`endif
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed self-checking bench for data_mem_bridge (DEPTH = 4).
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic        cpu_read, cpu_write, stall, mem_req, mem_we, mem_ack;
  logic [29:0] mem_addr;
  logic [2:0]  wb_count;

  int checks = 0;
  int errors = 0;

  bit          log_we   [$];
  logic [29:0] log_addr [$];
  logic [31:0] log_data [$];

  always #5 clk = ~clk;

  data_mem_bridge #(.DEPTH(4), .CW(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_count(wb_count)
  );

  // Record every completed memory transaction in issue order.
  always @(negedge clk) begin
    if (reset && mem_req && mem_ack) begin
      log_we.push_back(mem_we);
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_we.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic test_reset();
    #2;
    cpu_read = 1'b1;
    cpu_write = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b expected 0", stall); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req got %b expected 0", mem_req); end
    checks++; if (wb_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_wb_count got %0d expected 0", wb_count); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_cpu_rdata got %h expected 0", cpu_rdata); end
    checks++; if (mem_addr !== 30'h0) begin errors++; $display("[TB] FAIL reset_mem_addr got %h expected 0", mem_addr); end
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_mem_req got %b expected 0", mem_req); end
    tick();
  endtask

  task automatic test_posted_stores();
    logic [31:0] vals [4];
    vals = '{32'h11, 32'h22, 32'h33, 32'h44};
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_write = 1'b1;
      cpu_addr = 32'(i * 4);
      cpu_wdata = vals[i];
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL posted_stall_%0d got %b expected 0", i, stall); end
      tick();
    end
    cpu_addr = 32'h10;
    cpu_wdata = 32'h55;
    @(negedge clk);
    checks++; if (wb_count !== 3'd4) begin errors++; $display("[TB] FAIL full_wb_count got %0d expected 4", wb_count); end
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL full_stall got %b expected 1", stall); end
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("[TB] FAIL drain_req got req=%b we=%b expected 1 1", mem_req, mem_we); end
    checks++; if (mem_addr !== 30'h0 || mem_wdata !== 32'h11) begin errors++; $display("[TB] FAIL drain_head got %h/%h expected 0/11", mem_addr, mem_wdata); end
    tick();
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL full_stall_hold got %b expected 1", stall); end
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL full_stall_ack got %b expected 1", stall); end
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL after_ack_stall got %b expected 0", stall); end
    checks++; if (wb_count !== 3'd3) begin errors++; $display("[TB] FAIL after_ack_count got %0d expected 3", wb_count); end
    checks++; if (mem_addr !== 30'h1 || mem_wdata !== 32'h22) begin errors++; $display("[TB] FAIL second_head got %h/%h expected 1/22", mem_addr, mem_wdata); end
    tick();
    cpu_write = 1'b0;
    @(negedge clk);
    checks++; if (wb_count !== 3'd4) begin errors++; $display("[TB] FAIL fifth_push_count got %0d expected 4", wb_count); end
  endtask

  task automatic test_async_reset();
    #1;
    cpu_read = 1'b1;
    reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL async_mem_req got %b expected 0", mem_req); end
    checks++; if (wb_count !== 3'd0) begin errors++; $display("[TB] FAIL async_wb_count got %0d expected 0", wb_count); end
    checks++; if (mem_we !== 1'b0 || mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL async_mem_we_wdata got %b/%h expected 0/0", mem_we, mem_wdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL async_stall got %b expected 0", stall); end
    cpu_read = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || wb_count !== 3'd0) begin errors++; $display("[TB] FAIL idle_after_reset got req=%b count=%0d expected 0 0", mem_req, wb_count); end
    tick();
  endtask

  task automatic test_ordering();
    int nstall;
    bit got;
    clear_log();
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE0001;
    cpu_write = 1'b1;
    cpu_addr = 32'h100;
    cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL order_store_stall got %b expected 0", stall); end
    tick();
    cpu_write = 1'b0;
    cpu_read = 1'b1;
    nstall = 0;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!stall) begin got = 1; break; end
      nstall++;
    end
    checks++; if (!got) begin errors++; $display("[TB] FAIL order_timeout got stall expected release"); end
`ifdef DMB_FORWARD_EN
    checks++; if (nstall != 1) begin errors++; $display("[TB] FAIL order_fwd_stalls got %0d expected 1", nstall); end
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL order_fwd_rdata got %h expected deadbeef", cpu_rdata); end
    tick();
    cpu_read = 1'b0;
    checks++; if (log_we.size() != 0) begin errors++; $display("[TB] FAIL order_fwd_nomem got %0d expected 0", log_we.size()); end
`else
    checks++; if (nstall != 3) begin errors++; $display("[TB] FAIL order_stalls got %0d expected 3", nstall); end
    checks++; if (cpu_rdata !== 32'hCAFE0001) begin errors++; $display("[TB] FAIL order_rdata got %h expected cafe0001", cpu_rdata); end
    tick();
    cpu_read = 1'b0;
    checks++;
    if (log_we.size() != 2) begin
      errors++; $display("[TB] FAIL order_count got %0d expected 2", log_we.size());
    end else begin
      checks++; if (log_we[0] !== 1'b1 || log_addr[0] !== 30'h40 || log_data[0] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL order_first got %b/%h/%h expected 1/40/deadbeef", log_we[0], log_addr[0], log_data[0]); end
      checks++; if (log_we[1] !== 1'b0 || log_addr[1] !== 30'h40) begin errors++; $display("[TB] FAIL order_second got %b/%h expected 0/40", log_we[1], log_addr[1]); end
    end
`endif
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_count == 3'd0 && !mem_req) break;
    end
    checks++; if (wb_count !== 3'd0) begin errors++; $display("[TB] FAIL order_drain got %0d expected 0", wb_count); end
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_rw_conflict();
    int nstall;
    bit got;
    clear_log();
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    cpu_read = 1'b1;
    cpu_write = 1'b1;
    cpu_addr = 32'h8;
    cpu_wdata = 32'hFFFF0000;
    nstall = 0;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!stall) begin got = 1; break; end
      nstall++;
    end
    checks++; if (!got) begin errors++; $display("[TB] FAIL conflict_timeout got stall expected release"); end
    checks++; if (nstall != 2) begin errors++; $display("[TB] FAIL conflict_stalls got %0d expected 2", nstall); end
    checks++; if (cpu_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL conflict_rdata got %h expected 12345678", cpu_rdata); end
    tick();
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (wb_count !== 3'd0) begin errors++; $display("[TB] FAIL conflict_no_push got %0d expected 0", wb_count); end
    checks++;
    if (log_we.size() != 1) begin
      errors++; $display("[TB] FAIL conflict_count got %0d expected 1", log_we.size());
    end else begin
      checks++; if (log_we[0] !== 1'b0 || log_addr[0] !== 30'h2) begin errors++; $display("[TB] FAIL conflict_read got %b/%h expected 0/2", log_we[0], log_addr[0]); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    clear_log();
    mem_ack = 1'b0;
    cpu_write = 1'b1;
    cpu_addr = 32'h200; cpu_wdata = 32'hA0;
    tick();
    cpu_addr = 32'h204; cpu_wdata = 32'hB0;
    tick();
    cpu_write = 1'b0;
    @(negedge clk);
    checks++; if (wb_count !== 3'd2 || mem_addr !== 30'h80) begin errors++; $display("[TB] FAIL b2b_setup got %0d/%h expected 2/80", wb_count, mem_addr); end
    tick();
    cpu_write = 1'b1;
    cpu_addr = 32'h208; cpu_wdata = 32'hC0;
    mem_ack = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL b2b_push_stall got %b expected 0", stall); end
    tick();
    cpu_write = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (wb_count !== 3'd2) begin errors++; $display("[TB] FAIL b2b_count got %0d expected 2", wb_count); end
    checks++; if (mem_addr !== 30'h81 || mem_wdata !== 32'hB0) begin errors++; $display("[TB] FAIL b2b_next_head got %h/%h expected 81/b0", mem_addr, mem_wdata); end
    tick();
    mem_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_count == 3'd0 && !mem_req) break;
    end
    tick();
    mem_ack = 1'b0;
    checks++;
    if (log_we.size() != 3) begin
      errors++; $display("[TB] FAIL b2b_log_count got %0d expected 3", log_we.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (log_addr[i] !== 30'(32'h80 + i) || log_data[i] !== 32'hA0 + 32'(16 * i)) begin errors++; $display("[TB] FAIL b2b_entry_%0d got %h/%h expected %h/%h", i, log_addr[i], log_data[i], 32'h80 + i, 32'hA0 + 16 * i); end
      end
    end
    clear_log();
    for (int i = 0; i < 4; i++) begin
      cpu_write = 1'b1;
      cpu_addr = 32'h300 + 32'(4 * i);
      cpu_wdata = 32'hD0 + 32'(i);
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL wrap_stall_%0d got %b expected 0", i, stall); end
      tick();
    end
    cpu_write = 1'b0;
    @(negedge clk);
    checks++; if (wb_count !== 3'd4) begin errors++; $display("[TB] FAIL wrap_full got %0d expected 4", wb_count); end
    tick();
    mem_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_count == 3'd0 && !mem_req) break;
    end
    tick();
    mem_ack = 1'b0;
    checks++;
    if (log_we.size() != 4) begin
      errors++; $display("[TB] FAIL wrap_log_count got %0d expected 4", log_we.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (log_addr[i] !== 30'(32'hC0 + i) || log_data[i] !== 32'hD0 + 32'(i)) begin errors++; $display("[TB] FAIL wrap_entry_%0d got %h/%h expected %h/%h", i, log_addr[i], log_data[i], 32'hC0 + i, 32'hD0 + i); end
      end
    end
  endtask

`ifdef DMB_FORWARD_EN
  task automatic test_forward();
    clear_log();
    mem_ack = 1'b0;
    cpu_write = 1'b1;
    cpu_addr = 32'h20; cpu_wdata = 32'h5;
    tick();
    cpu_wdata = 32'h9;
    tick();
    cpu_write = 1'b0;
    cpu_read = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 1'b1 || mem_wdata !== 32'h5) begin errors++; $display("[TB] FAIL fwd_inflight got %b/%h expected 1/5", stall, mem_wdata); end
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b0 || cpu_rdata !== 32'h9) begin errors++; $display("[TB] FAIL fwd_hit got %b/%h expected 0/9", stall, cpu_rdata); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL fwd_no_req got %b expected 0", mem_req); end
    tick();
    cpu_read = 1'b0;
    cpu_write = 1'b1;
    cpu_addr = 32'h30; cpu_wdata = 32'h77;
    tick();
    cpu_write = 1'b0;
    cpu_read = 1'b1;
    cpu_addr = 32'h40;
    mem_rdata = 32'hABCD;
    tick();
    mem_ack = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (mem_we !== 1'b0 || mem_addr !== 30'h10 || wb_count !== 3'd1) begin errors++; $display("[TB] FAIL fwd_read_first got %b/%h/%0d expected 0/10/1", mem_we, mem_addr, wb_count); end
    tick();
    @(negedge clk);
    checks++; if (stall !== 1'b0 || cpu_rdata !== 32'hABCD) begin errors++; $display("[TB] FAIL fwd_miss_rdata got %b/%h expected 0/abcd", stall, cpu_rdata); end
    tick();
    cpu_read = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_count == 3'd0 && !mem_req) break;
    end
    tick();
    mem_ack = 1'b0;
    checks++; if (wb_count !== 3'd0) begin errors++; $display("[TB] FAIL fwd_drain got %0d expected 0", wb_count); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_posted_stores();
    test_async_reset();
    test_ordering();
    test_rw_conflict();
    test_back_to_back();
`ifdef DMB_FORWARD_EN
    test_forward();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
